// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace-line serializer.
//   - ASCII constants for the fixed punctuation of a trace line
//   - record kind encoding (register write / memory write)
//   - BCD digit vector type used by the decimal fields
//   - nibble/digit to ASCII helpers (hex is lowercase)
package cpu_trace_pkg;

    localparam int TIME_DIGITS_MAX = 4;

    typedef logic [TIME_DIGITS_MAX-1:0][3:0] bcd_t;   // [0] = ones digit

    typedef enum logic {
        KIND_REG = 1'b0,
        KIND_MEM = 1'b1
    } kind_e;

    localparam logic [7:0] CH_CARET  = 8'h5E;   // ^
    localparam logic [7:0] CH_AT     = 8'h40;   // @
    localparam logic [7:0] CH_COLON  = 8'h3A;   // :
    localparam logic [7:0] CH_DOLLAR = 8'h24;   // $
    localparam logic [7:0] CH_STAR   = 8'h2A;   // *
    localparam logic [7:0] CH_LT     = 8'h3C;   // <
    localparam logic [7:0] CH_EQ     = 8'h3D;   // =
    localparam logic [7:0] CH_HASH   = 8'h23;   // #
    localparam logic [7:0] CH_SPACE  = 8'h20;   // space

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 'a' is 8'h61, so 8'h57 + 10 lands on it
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h57 + {4'b0, n});
    endfunction

    function automatic logic [7:0] dec_ascii(input logic [3:0] d);
        return 8'h30 + {4'b0, d};
    endfunction

    // j = 0 selects the most significant nibble of w
    function automatic logic [3:0] hex_nibble(input logic [31:0] w, input logic [2:0] j);
        return w[{~j, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/trace_bin2dec.sv
// Combinational binary to BCD converter for the decimal trace fields.
// Ports:
//   bin       in  14  binary value, expected <= 9999 (caller clamps)
//   digits    out 16  four BCD digits, digits[0] = ones
//   n_digits  out 3   significant digit count, 1..4 (value 0 counts as 1)
module trace_bin2dec
    import cpu_trace_pkg::*;
(
    input  logic [13:0] bin,
    output bcd_t        digits,
    output logic [2:0]  n_digits
);

    logic [15:0] bcd;

    // Shift-and-add-3: a fifth decimal digit would fall off the top,
    // which is why the caller clamps to 9999 first.
    always_comb begin
        bcd = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < TIME_DIGITS_MAX; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], bin[i]};
        end
    end

    assign digits = bcd_t'(bcd);

    always_comb begin
        if (digits[3] != 4'd0)      n_digits = 3'd4;
        else if (digits[2] != 4'd0) n_digits = 3'd3;
        else if (digits[1] != 4'd0) n_digits = 3'd2;
        else                        n_digits = 3'd1;
    end

endmodule

// File: rtl/cpu_trace_serializer.sv
// Serializes one CPU write-back record per handshake into an ASCII trace
// line, one character per clock:
//   ^<time>@<pc>: $<reg> <= <data>#     (register write)
//   ^<time>@<pc>: *<addr> <= <data>#    (memory write)
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high
//   in_valid    in   1   record presented
//   in_ready    out  1   record accepted on the next edge when in_valid=1
//   in_kind     in   1   0 = register write, 1 = memory write
//   in_time     in   14  cycle stamp (decimal, clamped to TIME_MAX)
//   in_pc       in   32  PC (8 hex digits)
//   in_reg      in   5   register index (decimal), register writes only
//   in_addr     in   32  memory address (8 hex digits), memory writes only
//   in_data     in   32  written value (8 hex digits)
//   char        out  8   registered ASCII output
//   char_valid  out  1   char belongs to a line
//   busy        out  1   line in progress
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no line; char = IDLE_CHAR, in_ready = 1
// ST_EMIT | char shows line[pos]; in_ready = 1 only while showing '#'
module cpu_trace_serializer
    import cpu_trace_pkg::*;
#(
    parameter logic [7:0]  IDLE_CHAR = 8'h00,
    parameter int unsigned TIME_MAX  = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        busy
);

    // Never let the time field exceed four digits, whatever TIME_MAX says.
    localparam logic [13:0] TIME_CLAMP = (TIME_MAX > 32'd9999) ? 14'd9999 : 14'(TIME_MAX);

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t      state;
    logic [5:0]  pos;
    logic [5:0]  last_pos;

    kind_e       kind_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    bcd_t        time_dig_q;
    logic [2:0]  time_n_q;
    bcd_t        reg_dig_q;
    logic [2:0]  reg_n_q;

    logic [13:0] time_clamped;
    bcd_t        time_dig;
    logic [2:0]  time_n;
    bcd_t        reg_dig;
    logic [2:0]  reg_n;
    logic [5:0]  new_last;
    logic        accept;

    logic [5:0]  nxt;
    logic [5:0]  p_at;
    logic [5:0]  p_tg;
    logic [5:0]  p_tail;
    logic [7:0]  next_char;

    assign time_clamped = (in_time > TIME_CLAMP) ? TIME_CLAMP : in_time;

    trace_bin2dec u_time_dec (
        .bin      (time_clamped),
        .digits   (time_dig),
        .n_digits (time_n)
    );

    trace_bin2dec u_reg_dec (
        .bin      ({9'd0, in_reg}),
        .digits   (reg_dig),
        .n_digits (reg_n)
    );

    // Last index = 26 + time digits + target length - 1.
    assign new_last = 6'd25 + {3'b0, time_n} + (in_kind ? 6'd8 : {3'b0, reg_n});

    // in_ready stays combinational so it rises in the very first cycle after
    // reset releases and during the '#' cycle, allowing back-to-back lines.
    assign in_ready = ~reset & ((state == ST_IDLE) | (pos == last_pos));
    assign accept   = in_valid & in_ready;

    // Character at index pos+1 of the latched line. Field boundaries move
    // with the time digit count and the target length.
    assign nxt = pos + 6'd1;

    always_comb begin
        p_at      = 6'd1 + {3'b0, time_n_q};
        p_tg      = p_at + 6'd12;
        p_tail    = p_tg + ((kind_q == KIND_MEM) ? 6'd8 : {3'b0, reg_n_q});
        next_char = CH_HASH;
        if (nxt < p_at) begin
            next_char = dec_ascii(time_dig_q[2'({3'b0, time_n_q} - nxt)]);
        end else if (nxt == p_at) begin
            next_char = CH_AT;
        end else if (nxt <= p_at + 6'd8) begin
            next_char = hex_ascii(hex_nibble(pc_q, 3'(nxt - p_at - 6'd1)));
        end else if (nxt == p_at + 6'd9) begin
            next_char = CH_COLON;
        end else if (nxt == p_at + 6'd10) begin
            next_char = CH_SPACE;
        end else if (nxt == p_at + 6'd11) begin
            next_char = (kind_q == KIND_MEM) ? CH_STAR : CH_DOLLAR;
        end else if (nxt < p_tail) begin
            if (kind_q == KIND_MEM) begin
                next_char = hex_ascii(hex_nibble(addr_q, 3'(nxt - p_tg)));
            end else begin
                next_char = dec_ascii(reg_dig_q[2'({3'b0, reg_n_q} - 6'd1 - (nxt - p_tg))]);
            end
        end else if (nxt == p_tail) begin
            next_char = CH_SPACE;
        end else if (nxt == p_tail + 6'd1) begin
            next_char = CH_LT;
        end else if (nxt == p_tail + 6'd2) begin
            next_char = CH_EQ;
        end else if (nxt == p_tail + 6'd3) begin
            next_char = CH_SPACE;
        end else if (nxt <= p_tail + 6'd11) begin
            next_char = hex_ascii(hex_nibble(data_q, 3'(nxt - p_tail - 6'd4)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pos        <= '0;
            last_pos   <= '0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            kind_q     <= KIND_REG;
            pc_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            time_dig_q <= '0;
            time_n_q   <= 3'd1;
            reg_dig_q  <= '0;
            reg_n_q    <= 3'd1;
        end else if (accept) begin
            // Reachable from IDLE or from the '#' cycle of the previous line.
            state      <= ST_EMIT;
            pos        <= '0;
            last_pos   <= new_last;
            char       <= CH_CARET;
            char_valid <= 1'b1;
            busy       <= 1'b1;
            kind_q     <= kind_e'(in_kind);
            pc_q       <= in_pc;
            addr_q     <= in_addr;
            data_q     <= in_data;
            time_dig_q <= time_dig;
            time_n_q   <= time_n;
            reg_dig_q  <= reg_dig;
            reg_n_q    <= reg_n;
        end else begin
            case (state)
                ST_IDLE: begin
                    char       <= IDLE_CHAR;
                    char_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                ST_EMIT: begin
                    if (pos == last_pos) begin
                        state      <= ST_IDLE;
                        char       <= IDLE_CHAR;
                        char_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        pos  <= nxt;
                        char <= next_char;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Directed bench for cpu_trace_serializer. Expected lines are formatted by
// the bench with $sformatf and queued character by character when a record
// is accepted; a negedge monitor pops and compares every emitted character.
module tb_cpu_trace_serializer;

    localparam logic [7:0] IDLE_CHAR = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_kind = 1'b0;
    logic [13:0] in_time = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_reg = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [7:0]  char;
    logic        char_valid;
    logic        busy;

    typedef struct {
        logic [7:0] ch;
        bit         last;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    cpu_trace_serializer #(
        .IDLE_CHAR (IDLE_CHAR),
        .TIME_MAX  (9999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_reg     (in_reg),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char       (char),
        .char_valid (char_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (char_valid) begin
            if (q.size() == 0) begin
                check("spurious_char", char_valid, 1'b0);
            end else begin
                e_mon = q.pop_front();
                check("line_char", char, e_mon.ch);
                check("ready_in_line", in_ready, e_mon.last);
            end
        end else begin
            check("idle_char", char, IDLE_CHAR);
            check("ready_idle", in_ready, !reset);
        end
        check("busy_eq_valid", busy, char_valid);
    end

    // Queue the model line, present the record, wait for the accept edge.
    task automatic send(input bit kind, input int t, input logic [31:0] pc,
                        input logic [4:0] rg, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold, output int len);
        string s;
        int    tc;
        bit    accepted;
        exp_t  e;
        tc = (t > 9999) ? 9999 : t;
        if (kind) s = $sformatf("^%0d@%08h: *%08h <= %08h#", tc, pc, addr, data);
        else      s = $sformatf("^%0d@%08h: $%0d <= %08h#", tc, pc, rg, data);
        len      = s.len();
        in_kind  = kind;
        in_time  = 14'(t);
        in_pc    = pc;
        in_reg   = rg;
        in_addr  = addr;
        in_data  = data;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (in_ready) begin
                for (int k = 0; k < len; k++) begin
                    e.ch   = s[k];
                    e.last = (k == len - 1);
                    q.push_back(e);
                end
                @(posedge clk);
                accepted = 1'b1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        check("accepted", accepted, 1'b1);
        acc_cyc = cyc;
        check("first_char", char, 8'h5E);
        check("first_valid", char_valid, 1'b1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && !char_valid) break;
            @(posedge clk);
            #1;
        end
        check("drained", q.size(), 0);
        check("post_idle", char, IDLE_CHAR);
    endtask

    initial begin
        int len1;
        int len2;
        int a1;
        #1;
        check("rst_char", char, IDLE_CHAR);
        check("rst_valid", char_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 check("ready_after_rst", in_ready, 1'b1);

        // register record
        send(1'b0, 242, 32'h0000_3004, 5'd31, 32'h0, 32'h1234_5678, 1'b0, len1);
        check("reg_len", len1, 31);
        drain();
        // memory record, lowercase hex
        send(1'b1, 338, 32'h0000_3130, 5'd0, 32'h0000_0088, 32'hffff_b528, 1'b0, len1);
        drain();
        // zeros
        send(1'b0, 0, 32'h0000_3000, 5'd0, 32'h0, 32'h0, 1'b0, len1);
        drain();
        // clamped time, single-digit reg, addr ignored
        send(1'b0, 12000, 32'hdead_beef, 5'd9, 32'h5555_aaaa, 32'habcd_ef01, 1'b0, len1);
        drain();
        // memory write with reg ignored, 1-digit time
        send(1'b1, 7, 32'h0040_0000, 5'd17, 32'h7fff_fffc, 32'h0000_000a, 1'b0, len1);
        drain();

        // back-to-back; second record's fields change mid-line of the first
        send(1'b0, 1234, 32'h0000_3010, 5'd10, 32'h0, 32'h0000_00ff, 1'b1, len1);
        a1 = acc_cyc;
        send(1'b1, 9999, 32'h0000_3014, 5'd3, 32'h1000_0ffc, 32'hcafe_f00d, 1'b0, len2);
        check("b2b_gap", acc_cyc - a1, len1);
        drain();

        // reset mid-line at the 10th character
        send(1'b0, 56, 32'h0000_3020, 5'd4, 32'h0, 32'h8765_4321, 1'b0, len1);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_char", char, IDLE_CHAR);
        check("abort_valid", char_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", in_ready, 1'b0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("ready_after_abort", in_ready, 1'b1);
        send(1'b1, 4096, 32'h0000_3024, 5'd0, 32'hc0de_0010, 32'h0bad_f00d, 1'b0, len1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_trace_serializer.md
# cpu_trace_serializer

Formats one CPU write-back record per handshake into the ASCII trace line consumed by `cpu_checker`, one character per clock. Register writes are emitted as `^<time>@<pc>: $<reg> <= <data>#` and memory writes as `^<time>@<pc>: *<addr> <= <data>#`. The block sits directly upstream of `cpu_checker`, and its `char` output connects straight to the checker's `char` input.

## Interface
- `IDLE_CHAR`, default 8'h00: character driven whenever no line is being emitted.
- `TIME_MAX`, default 9999: `in_time` values above this are clamped to it, so the time field never exceeds 4 digits.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, async active-high reset.
- `in_valid`  in  1  a record is presented.
- `in_ready`  out  1  the block accepts the record on this edge.
- `in_kind`  in  1  0 = register write (`$`), 1 = memory write (`*`).
- `in_time`  in  14  cycle stamp, emitted in decimal.
- `in_pc`  in  32  PC, emitted as 8 hex digits.
- `in_reg`  in  5  GRF index, emitted in decimal (used when `in_kind`=0).
- `in_addr`  in  32  memory address, emitted as 8 hex digits (used when `in_kind`=1).
- `in_data`  in  32  written value, emitted as 8 hex digits.
- `char`  out  8  registered ASCII output.
- `char_valid`  out  1  `char` belongs to a line.
- `busy`  out  1  a line is in progress.

## Operation
- Two-state FSM.
  - IDLE: `in_ready`=1.
  - EMIT: a position counter walks the line.
- Accept = `in_valid && in_ready`. On accept:
  - Latch all fields.
  - Clamp time.
  - Precompute the decimal digits of time and reg.
  - Go to EMIT with position 0.
- Line layout, with no gaps and no padding:
  - `^`, time, `@`, pc, `:`, space, `$` or `*`, target, space, `<`, `=`, space, data, `#`.
- Decimal fields (time, reg):
  - Most significant non-zero digit first, no leading zeros.
  - Value 0 is emitted as a single `0`.
  - Time is 1–4 digits; reg is 1–2 digits.
- Hex fields (pc, addr, data): exactly 8 digits, leading zeros kept, lowercase `a`–`f`.
- Line length = 26 + time digits + target length.
  - Target length is 1–2 for a register target and 8 for a memory target.
- `in_ready` is also 1 during the cycle whose registered output will be `#`. This allows back-to-back lines: `^` follows `#` with no idle cycle.
- When a line ends without a new accept, return to IDLE. `char` = `IDLE_CHAR` and `char_valid` = 0 until the next line.
- `in_kind`=0 ignores `in_addr`; `in_kind`=1 ignores `in_reg`.

## Timing
- Reset values: `char`=`IDLE_CHAR`, `char_valid`=0, `busy`=0, `in_ready`=0 while `reset` is high, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-line aborts the line immediately: `char` returns to `IDLE_CHAR` and the latched record is discarded, not resumed.
- First `in_ready`=1 occurs in the first cycle after `reset` deasserts.
- Latency: accept on edge N → `char`=`^` after edge N; then one character per edge. `#` appears after edge N+L−1, where L is the line length.
- `busy` = `char_valid` = 1 exactly while `char` holds a line character.
- Input fields are sampled only on the accept edge. Changes to them afterwards do not affect the line in progress.
- `in_valid` held high with no accept (mid-line) is simply waiting; no record is lost or duplicated.

## Structure
- Package `cpu_trace_pkg`:
  - ASCII constants (`^ @ : $ * < = #`, space).
  - Kind encoding.
  - Hex-nibble-to-ASCII function (lowercase).
  - Decimal-digit-to-ASCII function.
  - `TIME_DIGITS_MAX`=4.
- Sub-module `trace_bin2dec`: combinational 14-bit → 4 BCD digits plus a significant-digit count. It is instantiated for time and also reused for reg (zero-extended).
- Everything else stays in the top module: FSM, position counter, field-select mux, output register.

## Test plan
- Register record: time=242, pc=0x00003004, reg=31, data=0x12345678 → `^242@00003004: $31 <= 12345678#` (31 chars), then `IDLE_CHAR`.
- Memory record: time=338, pc=0x00003130, addr=0x00000088, data=0xffffb528 → `^338@00003130: *00000088 <= ffffb528#`, lowercase hex.
- Boundary values:
  - time=0, reg=0, data=0 → `^0@...: $0 <= 00000000#`.
  - time=12000 → clamped field `9999`.
  - reg=9 → one digit.
- Back-to-back: `in_valid` held high with two records → second `^` appears on the edge immediately after the first `#`; `in_ready` pulses only at IDLE and at the `#` cycle.
- Reset mid-line: assert `reset` at the 10th character → `char`=`IDLE_CHAR` with no clock edge; after release, a fresh record emits a complete, correct line.
- Checker pass-through: drive `char` into `cpu_checker` for both kinds → the checker reports register format and memory format respectively, with no error.
